// File: rtl/batch_reverse_buffer_if.sv
// Handshake bundle for the batch reverse buffer: chronological input stream,
// batch-reversed output stream with first/last markers.
interface batch_reverse_buffer_if #(
  parameter int N = 3
);
  logic [N-1:0] in;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out;
  logic         out_valid;
  logic         out_ready;
  logic         out_first;
  logic         out_last;

  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out, out_valid, out_first, out_last
  );

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out, out_valid, out_first, out_last
  );
endinterface

// File: rtl/batch_reverse_buffer.sv
// Ping-pong batch reorder buffer: fills one bank chronologically while the
// other is replayed newest-first, so each DEPTH-sample batch comes out reversed.
//
// state | meaning
// EMPTY | bank holds no samples, may be selected for writing
// FILL  | bank partially written
// FULL  | all DEPTH samples written, not yet read
// DRAIN | reading in progress, newest to oldest
module batch_reverse_buffer #(
  parameter int N     = 3,
  parameter int DEPTH = 32
) (
  input logic                 clk,
  input logic                 rst,
  batch_reverse_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {EMPTY, FILL, FULL, DRAIN} bank_state_e;

  bank_state_e   state_q [2];
  bank_state_e   state_d [2];
  logic          wb_q, wb_d;
  logic          rb_q, rb_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] rcnt_q, rcnt_d;
  logic [N-1:0]  out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          out_first_q, out_first_d;
  logic          out_last_q, out_last_d;
  logic [N-1:0]  mem_q [2][DEPTH];

  logic in_ready;
  logic accept;
  logic issue;

  // Ready depends only on registered bank state, never on the consumer.
  assign in_ready = (state_q[wb_q] == EMPTY) || (state_q[wb_q] == FILL);
  assign accept   = bus.in_valid && in_ready;
  assign issue    = (!out_valid_q || bus.out_ready) &&
                    ((state_q[rb_q] == FULL) || (state_q[rb_q] == DRAIN));

  always_comb begin
    state_d     = state_q;
    wb_d        = wb_q;
    rb_d        = rb_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;

    // Writer and reader always sit on different banks when both are active.
    if (accept) begin
      if (wcnt_q == LAST_ADDR) begin
        state_d[wb_q] = FULL;
        wcnt_d        = '0;
        wb_d          = ~wb_q;
      end else begin
        state_d[wb_q] = FILL;
        wcnt_d        = wcnt_q + AW'(1);
      end
    end

    if (issue) begin
      out_d       = mem_q[rb_q][rcnt_q];
      out_valid_d = 1'b1;
      out_first_d = (rcnt_q == LAST_ADDR);
      out_last_d  = (rcnt_q == '0);
      if (rcnt_q == '0) begin
        state_d[rb_q] = EMPTY;
        rcnt_d        = LAST_ADDR;
        rb_d          = ~rb_q;
      end else begin
        state_d[rb_q] = DRAIN;
        rcnt_d        = rcnt_q - AW'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q[0]  <= EMPTY;
      state_q[1]  <= EMPTY;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= LAST_ADDR;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  // Sample storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem_q[wb_q][wcnt_q] <= bus.in;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;
endmodule
